// File: rtl/regfile_writeback_queue.sv
// Register-file write-back queue.
// Buffers write-back requests in a small FIFO and drains one per cycle into the
// register file write port. Pending writes, including the one currently on the
// write port, are visible to the two read selects as bypass data.
module regfile_writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AW-1:0]            req_reg,
  input  logic [DW-1:0]            req_data,
  input  logic                     stall,
  output logic [AW-1:0]            wr_reg,
  output logic [DW-1:0]            wr_data,
  output logic                     wr_Ld,
  input  logic [AW-1:0]            select_reg_A,
  input  logic [AW-1:0]            select_reg_B,
  output logic                     fwd_hit_A,
  output logic                     fwd_hit_B,
  output logic [DW-1:0]            fwd_data_A,
  output logic [DW-1:0]            fwd_data_B,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] reg_mem_q  [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] wr_reg_q;
  logic [DW-1:0] wr_data_q;
  logic          wr_ld_q;
  logic          push, pop;

  logic [1:0][AW-1:0] sel;
  logic [1:0]         hit;
  logic [1:0][DW-1:0] fdat;

  assign req_ready = (count_q < CW'(DEPTH));
  // Writes to register 0 complete the handshake but never take an entry.
  assign push      = req_valid & req_ready & (req_reg != '0);
  assign pop       = ~stall & (count_q != '0);

  // Head/tail pointers and occupancy.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset needed.
  always_ff @(posedge Clk) begin
    if (push) begin
      reg_mem_q[tail_q]  <= req_reg;
      data_mem_q[tail_q] <= req_data;
    end
  end

  // Registered write port: one Ld pulse per popped entry, reg/data hold otherwise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ld_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_ld_q <= pop;
      if (pop) begin
        wr_reg_q  <= reg_mem_q[head_q];
        wr_data_q <= data_mem_q[head_q];
      end
    end
  end

  assign sel = {select_reg_B, select_reg_A};

  // Bypass lookup: write-port stage first, then queue oldest to youngest so the
  // youngest matching entry overrides everything older.
  always_comb begin
    hit  = '0;
    fdat = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      if (sel[p] != '0) begin
        if (wr_ld_q && (wr_reg_q == sel[p])) begin
          hit[p]  = 1'b1;
          fdat[p] = wr_data_q;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if ((CW'(i) < count_q) && (reg_mem_q[head_q + PW'(i)] == sel[p])) begin
            hit[p]  = 1'b1;
            fdat[p] = data_mem_q[head_q + PW'(i)];
          end
        end
      end
    end
  end

  assign fwd_hit_A  = hit[0];
  assign fwd_hit_B  = hit[1];
  assign fwd_data_A = fdat[0];
  assign fwd_data_B = fdat[1];
  assign wr_reg     = wr_reg_q;
  assign wr_data    = wr_data_q;
  assign wr_Ld      = wr_ld_q;
  assign count      = count_q;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based reference model.
module tb_regfile_writeback_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;

  logic          Clk;
  logic          Reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_reg;
  logic [DW-1:0] req_data;
  logic          stall;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic          wr_Ld;
  logic [AW-1:0] select_reg_A;
  logic [AW-1:0] select_reg_B;
  logic          fwd_hit_A;
  logic          fwd_hit_B;
  logic [DW-1:0] fwd_data_A;
  logic [DW-1:0] fwd_data_B;
  logic [2:0]    count;

  int checks   = 0;
  int failures = 0;

  regfile_writeback_queue #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_reg      (req_reg),
    .req_data     (req_data),
    .stall        (stall),
    .wr_reg       (wr_reg),
    .wr_data      (wr_data),
    .wr_Ld        (wr_Ld),
    .select_reg_A (select_reg_A),
    .select_reg_B (select_reg_B),
    .fwd_hit_A    (fwd_hit_A),
    .fwd_hit_B    (fwd_hit_B),
    .fwd_data_A   (fwd_data_A),
    .fwd_data_B   (fwd_data_B),
    .count        (count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: pending writes in acceptance order plus the write-port stage.
  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic          m_ld;
  logic [AW-1:0] m_reg;
  logic [DW-1:0] m_data;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mq.delete();
      m_ld   = 1'b0;
      m_reg  = '0;
      m_data = '0;
    end else begin
      automatic bit ready = (mq.size() < DEPTH);
      if (!stall && mq.size() > 0) begin
        m_ld   = 1'b1;
        m_reg  = mq[0].r;
        m_data = mq[0].d;
        void'(mq.pop_front());
      end else begin
        m_ld = 1'b0;
      end
      if (req_valid && ready && req_reg != 0) mq.push_back('{r: req_reg, d: req_data});
    end
  end

  // Youngest pending write wins; the write-port stage is the oldest candidate.
  function automatic void mfwd(input logic [AW-1:0] s, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (s == 0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].r == s) begin
        h = 1'b1;
        d = mq[i].d;
        return;
      end
    end
    if (m_ld && m_reg == s) begin
      h = 1'b1;
      d = m_data;
    end
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    logic          ha, hb;
    logic [DW-1:0] da, db;
    mfwd(select_reg_A, ha, da);
    mfwd(select_reg_B, hb, db);
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
    chk("m_wr_Ld", 32'(wr_Ld), 32'(m_ld));
    chk("m_wr_reg", 32'(wr_reg), 32'(m_reg));
    chk("m_wr_data", wr_data, m_data);
    chk("m_fwd_hit_A", 32'(fwd_hit_A), 32'(ha));
    chk("m_fwd_data_A", fwd_data_A, da);
    chk("m_fwd_hit_B", 32'(fwd_hit_B), 32'(hb));
    chk("m_fwd_data_B", fwd_data_B, db);
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    Reset_n      = 1'b1;
    req_valid    = 1'b0;
    req_reg      = '0;
    req_data     = '0;
    stall        = 1'b0;
    select_reg_A = '0;
    select_reg_B = '0;
    #1 Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // Basic: r5 = 5, visible to forwarding until the register file latches.
    req_valid = 1'b1; req_reg = 5'd5; req_data = 32'h5; select_reg_A = 5'd5;
    step();
    req_valid = 1'b0;
    chk("basic_count_N", 32'(count), 32'd1);
    chk("basic_ld_N", 32'(wr_Ld), 32'd0);
    chk("basic_hit_N", 32'(fwd_hit_A), 32'd1);
    chk("basic_fdat_N", fwd_data_A, 32'h5);
    step();
    chk("basic_ld_N1", 32'(wr_Ld), 32'd1);
    chk("basic_reg_N1", 32'(wr_reg), 32'd5);
    chk("basic_data_N1", wr_data, 32'h5);
    chk("basic_hit_N1", 32'(fwd_hit_A), 32'd1);
    step();
    chk("basic_ld_N2", 32'(wr_Ld), 32'd0);
    chk("basic_hit_N2", 32'(fwd_hit_A), 32'd0);

    // Fill under stall, then drain in order; the held fifth request follows.
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      req_valid = 1'b1; req_reg = 5'(i); req_data = 32'(i);
      step();
    end
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ready", 32'(req_ready), 32'd0);
    req_reg = 5'd6; req_data = 32'h66;
    step();
    chk("fill_held_count", 32'(count), 32'd4);
    chk("fill_held_ld", 32'(wr_Ld), 32'd0);
    stall = 1'b0;
    step();
    chk("drain1_data", wr_data, 32'd1);
    chk("drain1_count", 32'(count), 32'd3);
    step();
    req_valid = 1'b0;
    chk("drain2_data", wr_data, 32'd2);
    chk("drain2_count", 32'(count), 32'd3);
    step();
    chk("drain3_data", wr_data, 32'd3);
    step();
    chk("drain4_data", wr_data, 32'd4);
    step();
    chk("drain5_reg", 32'(wr_reg), 32'd6);
    chk("drain5_data", wr_data, 32'h66);
    chk("drain5_ld", 32'(wr_Ld), 32'd1);
    step();
    chk("drain_done_ld", 32'(wr_Ld), 32'd0);

    // Forwarding priority: two writes to r7, the younger one wins.
    stall = 1'b1;
    req_valid = 1'b1; req_reg = 5'd7; req_data = 32'hA;
    step();
    req_data = 32'hB;
    step();
    req_valid = 1'b0; select_reg_B = 5'd7;
    #1;
    chk("prio_hit", 32'(fwd_hit_B), 32'd1);
    chk("prio_data", fwd_data_B, 32'hB);
    stall = 1'b0;
    step();
    chk("prio_wrA", wr_data, 32'hA);
    chk("prio_fwd_after_A", fwd_data_B, 32'hB);
    step();
    chk("prio_wrB", wr_data, 32'hB);
    chk("prio_fwd_wrstage", fwd_data_B, 32'hB);
    step();
    chk("prio_gone_hit", 32'(fwd_hit_B), 32'd0);
    chk("prio_gone_data", fwd_data_B, 32'd0);

    // Register 0: accepted, discarded, never forwarded.
    req_valid = 1'b1; req_reg = 5'd0; req_data = 32'hFFFF_FFFF; select_reg_A = 5'd0;
    #1;
    chk("r0_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("r0_count", 32'(count), 32'd0);
    chk("r0_hit", 32'(fwd_hit_A), 32'd0);
    step();
    chk("r0_ld", 32'(wr_Ld), 32'd0);

    // Reset mid-burst with three entries pending.
    stall = 1'b1;
    for (int i = 9; i <= 11; i++) begin
      req_valid = 1'b1; req_reg = 5'(i); req_data = 32'(i * 16);
      step();
    end
    req_valid = 1'b0;
    chk("mid_count", 32'(count), 32'd3);
    #1 Reset_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ld", 32'(wr_Ld), 32'd0);
    chk("mid_rst_reg", 32'(wr_reg), 32'd0);
    chk("mid_rst_data", wr_data, 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    stall = 1'b0;

    // Randomized traffic; stall toggles every 3 cycles at first to force wrap
    // with simultaneous push/pop, then goes random with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      @(posedge Clk);
      #1;
      req_valid    = ($urandom_range(0, 3) != 0);
      req_reg      = 5'($urandom_range(0, 7));
      req_data     = $urandom;
      select_reg_A = 5'($urandom_range(0, 7));
      select_reg_B = 5'($urandom_range(0, 7));
      if (c < 60) stall = 1'(((c / 3) % 2));
      else        stall = ($urandom_range(0, 3) == 0);
      Reset_n = (c < 60) || ($urandom_range(0, 299) != 0);
    end
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Buffers register-file write-back requests and drains them, one per cycle, into the register file's write port (`write_reg`, `data`, `Ld`). It sits between the execution/memory stages and the register file. It absorbs bursts while `stall` holds the write port. It also supplies bypass data to the two register-file read selects for writes that are still pending.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `DW`, 32: data width.
- `AW`, 5: register address width.

Ports:
- `Clk`  in  1: single clock; all state changes on its rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: write-back request present.
- `req_ready`  out  1: queue can accept; `req_ready = (count < DEPTH)`.
- `req_reg`  in  AW: destination register.
- `req_data`  in  DW: value to write.
- `stall`  in  1: when high, the queue does not drain.
- `wr_reg`  out  AW: to register file `write_reg`; registered.
- `wr_data`  out  DW: to register file `data`; registered.
- `wr_Ld`  out  1: to register file `Ld`; registered, one-cycle pulse per write.
- `select_reg_A`, `select_reg_B`  in  AW: the register file's read selects, mirrored.
- `fwd_hit_A`, `fwd_hit_B`  out  1: a pending write targets the selected register.
- `fwd_data_A`, `fwd_data_B`  out  DW: bypass value; 0 when there is no hit.
- `count`  out  log2(DEPTH)+1: current number of queued entries.

## Operation
- **Enqueue:** on a rising edge with `req_valid && req_ready` and `req_reg != 0`, write `{req_reg, req_data}` at the tail.
- **Register 0:** a request with `req_reg == 0` is accepted (handshake completes) but discarded. It never occupies an entry and never reaches `wr_*`.
- **Drain:** on a rising edge with `!stall && count > 0`:
  - pop the head;
  - `wr_reg <= head.reg`, `wr_data <= head.data`, `wr_Ld <= 1`.
- **No drain:** otherwise `wr_Ld <= 0` and `wr_reg`/`wr_data` hold their previous values.
- **Ordering:** strict FIFO. Writes reach the register file in acceptance order, so repeated writes to the same register resolve to the youngest.
- **Simultaneous enqueue and drain:** both happen on the same edge and `count` is unchanged.
  - When full, `req_ready = 0` even if a drain occurs on that edge; there is no full-queue pass-through.
  - When empty, an arriving request is queued and drains no earlier than the next edge; there is no bypass straight to `wr_*`.
- **Pointers:** head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty is derived from `count`.
- **Forwarding (combinational), per port X ∈ {A, B}:**
  - Candidates are every valid queue entry plus the `wr_*` stage while `wr_Ld = 1`. The `wr_*` stage counts because the register file has not yet latched it.
  - Priority: youngest queue entry (nearest tail), then older entries, then the `wr_*` stage.
  - `fwd_hit_X = 1` and `fwd_data_X` = the winning data when a candidate's reg equals `select_reg_X`.
  - `select_reg_X == 0` never hits.
- **Reset (`Reset_n` low, any time, including mid-burst):**
  - all pending entries are discarded;
  - `count = 0`, pointers = 0;
  - `wr_Ld = 0`, `wr_reg = 0`, `wr_data = 0`;
  - `req_ready = 1`, `fwd_hit_* = 0`, `fwd_data_* = 0`.
  - The queue resumes on the first rising edge after `Reset_n` rises.

## Timing
- Request accepted at edge N:
  - the earliest drain is edge N+1, so `wr_Ld` is high from N+1 to N+2;
  - the register file latches at edge N+2.
- Forwarding covers the whole window from edge N until the register file latches at N+2, so there is no visibility gap.
- Throughput is one write per cycle when `stall` is low.
- `req_ready`, `count` and `fwd_*` are valid the same cycle after each edge.
- `wr_Ld` is never high for two consecutive cycles unless the head is non-empty and unstalled on both edges.
- With `stall` held high, `DEPTH` requests fill the queue. `req_ready` drops the cycle after the `DEPTH`-th acceptance.

## Test plan
1. **Reset:** assert `Reset_n` = 0 mid-burst with `count = 3` → immediately `count = 0`, `wr_Ld = 0`, `wr_reg = 0`, `wr_data = 0`, `req_ready = 1`. After release, no stale write ever appears on `wr_*`.
2. **Basic:** enqueue r5 = 0x0000_0005 at edge N with `stall = 0` → `wr_reg = 5`, `wr_data = 5`, `wr_Ld = 1` for one cycle after edge N+1. `fwd_hit_A = 1` with `select_reg_A = 5` from edge N until N+2.
3. **Fill/stall:** with `stall = 1`, enqueue r1..r4 = 1..4 → `count = 4`, `req_ready = 0`. A fifth request is held. Release `stall` → `wr_*` emits 1, 2, 3, 4 on consecutive cycles. The held request is accepted on the edge after the first pop.
4. **Forwarding priority:** queue r7 = 0xA, then r7 = 0xB, with `select_reg_B = 7` → `fwd_data_B = 0xB`. After 0xB drains, the register file holds 0xB and `fwd_hit_B = 0`.
5. **Register 0:** `req_reg = 0`, data 0xFFFF_FFFF → handshake completes, `count` unchanged, `wr_Ld` never asserted. `select_reg_A = 0` gives `fwd_hit_A = 0`.
6. **Wrap and simultaneous events:** stream 12 requests with `stall` toggling every 3 cycles and enqueue/drain on the same edges → `count` stays correct, outputs appear in order, and pointers wrap with no loss or duplication.
